pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipelined CPU. It resolves three hazard sources: load-use in ID/EX, a taken branch resolved in EX, and multi-cycle data-memory waits in MEM. From these it drives per-stage write enables and flush (bubble-insert) strobes for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It also runs a memory-wait watchdog that halts the core, and saturating stall/flush performance counters.

Parameters:
TIMEOUT, 16, consecutive not-ready memory cycles before halt; 0 disables the watchdog
CNT_W, 16, width of performance counters
WAIT_W, 8, width of internal wait counter; must satisfy TIMEOUT < 2^WAIT_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
id_rs1_i  in  5  rs1 index of instruction in ID
id_rs2_i  in  5  rs2 index of instruction in ID
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  rd index of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  EX resolved a taken branch/jump (PC mux selects target)
mem_req_i  in  1  MEM instruction accesses data memory
mem_ready_i  in  1  data memory completes the access this cycle
pc_write_o  out  1  PC load enable
if_id_write_o  out  1  IF_ID load enable
if_id_flush_o  out  1  IF_ID loads NOP
id_ex_write_o  out  1  ID_EX load enable
id_ex_flush_o  out  1  ID_EX loads bubble (all controls 0)
ex_mem_write_o  out  1  EX_MEM load enable
mem_wb_flush_o  out  1  MEM_WB loads bubble
halt_o  out  1  core halted by watchdog (sticky)
stall_cnt_o  out  CNT_W  stall cycles (load-use + mem wait), saturating
flush_cnt_o  out  CNT_W  branch flush events, saturating

Behaviour:
- States: RUN, ERR. Reset puts the block in RUN with wait_cnt=0, halt_o=0, both counters 0.
- While rst_i is high: all write enables 0, all flushes 0.
- Hazard terms, combinational in RUN:
  - memwait = mem_req_i & ~mem_ready_i
  - loaduse = ex_mem_read_i & (ex_rd_i!=0) & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i))
  - branch = ex_branch_taken_i
- Priority is memwait > branch > loaduse. Exactly one case applies per cycle:
  - memwait: pc/if_id/id_ex/ex_mem writes 0; mem_wb_flush_o=1; other flushes 0.
  - branch (no memwait): all writes 1; if_id_flush_o=1; id_ex_flush_o=1. Load-use is ignored because the ID instruction is squashed.
  - loaduse only: pc_write_o=0, if_id_write_o=0; id_ex_flush_o=1; ex_mem_write_o=1.
  - none: all writes 1, all flushes 0.
- A branch or load-use held during memwait is deferred, not lost. EX is frozen, so the input persists and acts on the first cycle memwait clears. The hazard is counted once.
- Zero-latency decode: outputs depend on the current-cycle inputs and state only.
- Watchdog:
  - wait_cnt increments on each memwait cycle in RUN and clears on any non-memwait cycle.
  - If TIMEOUT!=0 and a memwait cycle occurs with wait_cnt==TIMEOUT-1, the next state is ERR.
  - The block therefore halts after exactly TIMEOUT consecutive stalled cycles.
- ERR: halt_o=1; all write enables 0; flushes 0; inputs ignored; counters frozen. Only rst_i exits ERR. Reset mid-wait or in ERR returns to RUN with everything cleared.
- Counters:
  - stall_cnt_o +1 on each RUN cycle with memwait or (loaduse & ~branch).
  - flush_cnt_o +1 on each RUN cycle with branch & ~memwait.
  - Both saturate at 2^CNT_W-1 with no wrap.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_use_rs1_i=1 for 1 cycle -> pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1 that cycle; stall_cnt_o=1. Repeat with ex_rd_i=0 -> no stall.
- Branch: ex_branch_taken_i=1 together with a matching load-use -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1; flush_cnt_o=1; stall_cnt_o unchanged.
- Mem wait with deferred branch: mem_req_i=1, mem_ready_i=0 for 3 cycles with ex_branch_taken_i=1 held -> 3 cycles of all writes 0 and mem_wb_flush_o=1; then mem_ready_i=1 -> flush asserted that cycle; stall_cnt_o=3, flush_cnt_o=1.
- Watchdog: TIMEOUT=16, memwait held 16 cycles -> halt_o=1 from cycle 17 with all enables 0. Ready then rises -> still halted. Assert rst_i mid-cycle -> halt_o=0 and counters 0 immediately (async).
- Saturation: CNT_W=4, 20 load-use cycles -> stall_cnt_o=15 and holds at 15.
- TIMEOUT=0: memwait held 300 cycles -> no halt, freeze sustained throughout.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer with memory-wait watchdog and perf counters
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int WAIT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_flush_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memwait, loaduse, branch, run, stall_inc, flush_inc;
  // hazard decode and per-stage strobes; memwait freezes everything upstream of MEM
  always_comb begin
    memwait        = mem_req_i & ~mem_ready_i;
    loaduse        = ex_mem_read_i & (ex_rd_i != 5'd0) &
                     ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                      (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    branch         = ex_branch_taken_i;
    run            = ~rst_i & (state == RUN);
    pc_write_o     = run & ~memwait & (branch | ~loaduse);
    if_id_write_o  = run & ~memwait & (branch | ~loaduse);
    if_id_flush_o  = run & ~memwait & branch;
    id_ex_write_o  = run & ~memwait;
    id_ex_flush_o  = run & ~memwait & (branch | loaduse);
    ex_mem_write_o = run & ~memwait;
    mem_wb_flush_o = run & memwait;
    stall_inc      = run & (memwait | (loaduse & ~branch));
    flush_inc      = run & branch & ~memwait;
  end
  assign halt_o = (state == ERR);
  // watchdog FSM and saturating counters; ERR holds everything until reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (state == RUN) begin
      wait_cnt <= memwait ? wait_cnt + 1'b1 : '0;
      if (memwait && TIMEOUT != 0 && wait_cnt == WAIT_LAST) state <= ERR;
      if (stall_inc && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_inc && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
endmodule
